ti_share_recombiner: RTL and testbench
======================================

Name: ti_share_recombiner

Overview:
- Decoding end of the masked S-box datapath: collects the output shares of a threshold-implementation S-box, arriving serially one share per beat, and XOR-recombines them into the unmasked value.
- Each group of NUM_SHARES beats yields one output word.
- Sits after the shared S-box stages and feeds unmasked results to the verification/observation logic.
- Valid/ready handshakes on both sides, with share-count framing checks.

Parameters:
- W, 8, width of one share and of the recombined output.
- NUM_SHARES, 3, shares per group; legal range 2..15.
- CNT_W, 16, width of the completed-group counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_valid  input  1  share beat valid.
- s_ready  output  1  share beat accepted when s_valid & s_ready.
- s_data  input  W  share value.
- s_last  input  1  marks the final share of a group.
- m_valid  output  1  recombined word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  W  recombined (unmasked) word.
- err_pulse  output  1  one-cycle pulse on a framing error.
- err_count  output  8  saturating count of framing errors.
- grp_count  output  CNT_W  wrapping count of words delivered (m handshakes).

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = ACC, share index = 0, accumulator = 0.
  - m_valid = 0, m_data = 0, err_pulse = 0, err_count = 0, grp_count = 0.
  - Reset mid-group discards any partial accumulation.
- States:
  - ACC: collecting shares.
  - HOLD: output word valid, waiting for m_ready.
- s_ready:
  - 1 in ACC.
  - Equals m_ready in HOLD, so a new group can start in the same cycle the held word drains.
- Beat accepted with index idx:
  - idx = 0: acc <= s_data.
  - Otherwise: acc <= acc ^ s_data.
- Non-final beat (idx < NUM_SHARES-1):
  - s_last = 0: idx++.
  - s_last = 1 (early last): framing error; group discarded, idx <= 0, stay ACC, no output.
- Final beat (idx = NUM_SHARES-1):
  - s_last = 1: m_data <= acc ^ s_data, m_valid <= 1, idx <= 0, go HOLD.
  - Latency is one cycle from the final beat to m_valid.
  - s_last = 0 (missing last): framing error; group discarded, idx <= 0, stay ACC.
- Framing error effects:
  - err_pulse high for exactly the following cycle.
  - err_count increments, saturating at 255.
- HOLD:
  - m_data and m_valid are held stable while m_ready = 0.
  - On m_ready = 1: m_valid <= 0, grp_count++ (wraps at 2^CNT_W), return to ACC.
  - If s_valid is also high in that cycle, the beat is accepted as idx 0 of the next group.
- Sustained throughput: with m_ready held at 1, one word every NUM_SHARES cycles.
- s_data and s_last are ignored when the beat is not accepted.
- m_valid never drops without an m_ready handshake, except on reset.

Test Plan:
- Shares 0x3C, 0xA5, 0x5A, s_last on the third, m_ready = 1 -> m_valid one cycle later with m_data = 0xC3; grp_count = 1; err_pulse stays 0.
- Beats 0x11, then 0x22 with s_last = 1, then a clean group 0x01, 0x02, 0x04 (last) -> err_pulse one cycle after the 0x22 beat, err_count = 1, no output for the bad group; next m_data = 0x07.
- Group 0xFF, 0x0F, 0xF0 (last), with m_ready low 5 cycles -> m_valid = 1 and m_data = 0x00 held for 5 cycles, s_ready = 0, a waiting s_valid is not consumed; on m_ready the pending beat is accepted in the same cycle.
- Three back-to-back groups with s_valid = 1 and m_ready = 1 continuously -> 3 words in 9 beats plus 1 cycle latency, no bubbles; grp_count = 3.
- Two beats accepted, then rst_n low for 1 cycle, then group 0xAA, 0x55, 0x00 (last) -> m_data = 0xFF with no contribution from pre-reset beats; all counters reset to 0 before the new group.
- 260 groups each missing s_last on the third beat -> err_count saturates at 255; err_pulse fires 260 times; grp_count = 0.

Source files
------------

// File: rtl/ti_share_recombiner.sv
// Purpose : XOR-recombines serially arriving threshold-implementation S-box
//           shares (one share per beat, NUM_SHARES beats per group) into the
//           unmasked word, with share-count framing checks.
// Latency : m_valid rises one cycle after the accepted final beat of a group.
// Backpr. : s_ready is 1 while collecting; while a word is held it follows
//           m_ready, so the next group can start in the cycle the word drains.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   s_valid/s_ready      share beat handshake; s_data share, s_last group end
//   m_valid/m_ready      recombined word handshake; m_data unmasked word
//   err_pulse            one-cycle pulse after a framing error
//   err_count            saturating (255) framing error count
//   grp_count            wrapping count of delivered words
module ti_share_recombiner #(
  parameter int W          = 8,
  parameter int NUM_SHARES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] grp_count
);

  // Index register is sized for the full legal share range (up to 15).
  localparam logic [3:0] LAST_IDX = 4'(NUM_SHARES - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             m_valid_q, m_valid_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [CNT_W-1:0] grp_count_q, grp_count_d;

  logic s_acc;
  logic frame_err;

  always_comb begin
    s_ready = (state_q == ACC) ? 1'b1 : m_ready;
  end

  assign s_acc = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    grp_count_d = grp_count_q;
    frame_err   = 1'b0;

    // Held word drains; any beat accepted this same cycle starts a new
    // group at index 0 (idx_q is always 0 while holding).
    if (state_q == HOLD && m_ready) begin
      m_valid_d   = 1'b0;
      grp_count_d = grp_count_q + 1'b1;
      state_d     = ACC;
    end

    if (s_acc) begin
      acc_d = (idx_q == 4'd0) ? s_data : (acc_q ^ s_data);
      if (idx_q == LAST_IDX) begin
        idx_d = 4'd0;
        if (s_last) begin
          m_data_d  = acc_q ^ s_data;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end else begin
          frame_err = 1'b1;   // missing last: group dropped
        end
      end else if (s_last) begin
        idx_d     = 4'd0;
        frame_err = 1'b1;     // early last: group dropped
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end

    if (frame_err) begin
      err_pulse_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACC;
      idx_q       <= 4'd0;
      acc_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
      grp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      grp_count_q <= grp_count_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign grp_count = grp_count_q;

endmodule

// File: tb/tb_ti_share_recombiner.sv
// Purpose : directed bench for ti_share_recombiner (W=8, NUM_SHARES=3).
// Timing  : inputs driven and outputs sampled 1 ns after each rising edge.
// Result  : one TB_RESULT summary line at the end.
module tb_ti_share_recombiner;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] grp_count;

  int checks   = 0;
  int failures = 0;

  ti_share_recombiner #(.W(8), .NUM_SHARES(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .grp_count (grp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  logic [7:0] b2b_dat [9];
  logic [7:0] b2b_exp [3];
  int         pulses;
  int         mv_seen;

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Reset state
    chk("rst_m_valid",   m_valid,   0);
    chk("rst_m_data",    m_data,    0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_grp_count", grp_count, 0);
    chk("rst_s_ready",   s_ready,   1);

    // Basic group: 3C ^ A5 ^ 5A = C3
    drive(1'b1, 8'h3C, 1'b0); cyc();
    chk("t1_no_early_valid", m_valid, 0);
    drive(1'b1, 8'hA5, 1'b0); cyc();
    drive(1'b1, 8'h5A, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("t1_m_valid",   m_valid,   1);
    chk("t1_m_data",    m_data,    8'hC3);
    chk("t1_err_pulse", err_pulse, 0);
    cyc();
    chk("t1_drained",   m_valid,   0);
    chk("t1_grp_count", grp_count, 1);

    // Early last, then a clean group 01^02^04 = 07
    drive(1'b1, 8'h11, 1'b0); cyc();
    drive(1'b1, 8'h22, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("t2_err_pulse",   err_pulse, 1);
    chk("t2_err_count",   err_count, 1);
    chk("t2_no_output",   m_valid,   0);
    cyc();
    chk("t2_pulse_1cyc",  err_pulse, 0);
    drive(1'b1, 8'h01, 1'b0); cyc();
    drive(1'b1, 8'h02, 1'b0); cyc();
    drive(1'b1, 8'h04, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_data",  m_data,  8'h07);
    cyc();
    chk("t2_grp_count", grp_count, 2);

    // Backpressure: FF^0F^F0 = 00 held for 5 cycles with a beat waiting
    m_ready = 1'b0;
    drive(1'b1, 8'hFF, 1'b0); cyc();
    drive(1'b1, 8'h0F, 1'b0); cyc();
    drive(1'b1, 8'hF0, 1'b1); cyc();
    drive(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_data",  m_data,  8'h00);
      chk("t3_s_ready_lo", s_ready, 0);
      cyc();
    end
    chk("t3_grp_unchanged", grp_count, 2);
    m_ready = 1'b1;
    #1;
    chk("t3_s_ready_follow", s_ready, 1);
    cyc();
    chk("t3_drained",   m_valid,   0);
    chk("t3_grp_count", grp_count, 3);
    // 0x33 was taken as share 0: 33^44^55 = 22
    drive(1'b1, 8'h44, 1'b0); cyc();
    drive(1'b1, 8'h55, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("t3_pending_valid", m_valid, 1);
    chk("t3_pending_data",  m_data,  8'h22);
    chk("t3_no_err",        err_count, 1);
    cyc();
    chk("t3_grp_after", grp_count, 4);

    // Back-to-back groups: no bubbles
    b2b_dat = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h40, 8'hF0, 8'h0F, 8'h11};
    b2b_exp = '{8'h00, 8'h70, 8'hEE};
    for (int k = 0; k < 9; k++) begin
      chk("t4_s_ready", s_ready, 1);
      drive(1'b1, b2b_dat[k], (k % 3) == 2);
      cyc();
      chk("t4_m_valid", m_valid, ((k % 3) == 2) ? 1 : 0);
      if ((k % 3) == 2) chk("t4_m_data", m_data, b2b_exp[k / 3]);
    end
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    chk("t4_grp_count", grp_count, 7);
    chk("t4_err_count", err_count, 1);

    // Reset mid-group discards partial accumulation
    drive(1'b1, 8'h12, 1'b0); cyc();
    drive(1'b1, 8'h34, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t5_grp_reset", grp_count, 0);
    chk("t5_err_reset", err_count, 0);
    chk("t5_mv_reset",  m_valid,   0);
    drive(1'b1, 8'hAA, 1'b0); cyc();
    drive(1'b1, 8'h55, 1'b0); cyc();
    drive(1'b1, 8'h00, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("t5_m_valid",   m_valid,   1);
    chk("t5_m_data",    m_data,    8'hFF);
    chk("t5_no_err",    err_pulse, 0);
    cyc();
    chk("t5_grp_count", grp_count, 1);

    // 260 groups missing last: saturation
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    pulses  = 0;
    mv_seen = 0;
    for (int g = 0; g < 260; g++) begin
      for (int b = 0; b < 3; b++) begin
        drive(1'b1, 8'(g + b), 1'b0);
        cyc();
        if (err_pulse) pulses++;
        if (m_valid) mv_seen++;
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    if (err_pulse) pulses++;
    chk("t6_err_pulses", pulses,    260);
    chk("t6_err_sat",    err_count, 8'hFF);
    chk("t6_grp_count",  grp_count, 0);
    chk("t6_no_output",  mv_seen,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
